// File: rtl/piece_spawner_if.sv
//------------------------------------------------------------------------------
// Module  : piece_spawner_if
// Brief   : Spawn request/acknowledge handshake between game top and spawner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface piece_spawner_if;
    logic       create_block;
    logic [2:0] piece_type;
    logic       created;

    modport master (
        output create_block,
        output piece_type,
        input  created
    );

    modport slave (
        input  create_block,
        input  piece_type,
        output created
    );
endinterface

`default_nettype wire

// File: rtl/piece_spawner.sv
//------------------------------------------------------------------------------
// Module  : piece_spawner
// Brief   : Builds the spawn mask for a requested piece, checks it against the
//           locked field, and either publishes the overlay or flags game over.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piece_spawner #(
    parameter int ROWS    = 24,
    parameter int COLS    = 10,
    parameter int SPAWN_X = 3,
    parameter int SPAWN_Y = 0
) (
    input  wire logic                 Clk,
    input  wire logic                 Reset_n,
    piece_spawner_if.slave            spawn_if,
    input  wire logic [ROWS*COLS-1:0] State,
    output logic      [ROWS*COLS-1:0] Show_State,
    output logic      [3:0]           X_Pos,
    output logic      [4:0]           Y_Pos,
    output logic                      piece_active,
    output logic                      game_over
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_OVER  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [15:0]          w_box;
    logic [ROWS*COLS-1:0] w_mask;
    logic [ROWS*COLS-1:0] r_mask;
    logic [ROWS*COLS-1:0] r_show;
    logic [3:0]           r_x;
    logic [4:0]           r_y;
    logic                 r_active;
    logic                 r_over;
    logic                 r_created;
    logic                 w_hit;
    logic                 w_accept;
    logic                 w_latch;
    logic                 w_commit;
    logic                 w_fail;
    logic                 w_ack_next;

    // 4x4 box, nibble j holds box row j, bit k of a nibble is box column k
    function automatic logic [15:0] box_of(input logic [2:0] t);
        logic [15:0] b;
        case (t)
            3'd0:    b = {4'b0000, 4'b0000, 4'b0000, 4'b1111};
            3'd2:    b = {4'b0000, 4'b0000, 4'b0111, 4'b0010};
            3'd3:    b = {4'b0000, 4'b0000, 4'b0011, 4'b0110};
            3'd4:    b = {4'b0000, 4'b0000, 4'b0110, 4'b0011};
            3'd5:    b = {4'b0000, 4'b0000, 4'b0111, 4'b0001};
            3'd6:    b = {4'b0000, 4'b0000, 4'b0111, 4'b0100};
            default: b = {4'b0000, 4'b0000, 4'b0110, 4'b0110};
        endcase
        return b;
    endfunction

    always_comb begin
        w_box = box_of(spawn_if.piece_type);
    end

    // Place the box in the field; bits outside the field are simply never generated
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (r >= SPAWN_Y && r < SPAWN_Y + 4 && c >= SPAWN_X && c < SPAWN_X + 4) begin : g_in
                assign w_mask[r*COLS+c] = w_box[(r-SPAWN_Y)*4 + (c-SPAWN_X)];
            end else begin : g_out
                assign w_mask[r*COLS+c] = 1'b0;
            end
        end
    end

    assign w_hit = |(State & r_mask);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (spawn_if.create_block && !r_over) w_state_next = c_LOAD;
            c_LOAD:  w_state_next = c_CHECK;
            c_CHECK: w_state_next = w_hit ? c_OVER : c_DONE;
            c_DONE:  if (!spawn_if.create_block) w_state_next = c_IDLE;
            c_OVER:  w_state_next = c_OVER;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == c_IDLE) && (w_state_next == c_LOAD);
        w_latch    = (r_state == c_LOAD);
        w_commit   = (r_state == c_CHECK) && !w_hit;
        w_fail     = (r_state == c_CHECK) && w_hit;
        w_ack_next = (w_state_next == c_DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_mask    <= '0;
            r_show    <= '0;
            r_x       <= 4'd0;
            r_y       <= 5'd0;
            r_active  <= 1'b0;
            r_over    <= 1'b0;
            r_created <= 1'b0;
        end else begin
            if (w_latch) begin
                r_mask <= w_mask;
            end
            if (w_accept) begin
                r_active <= 1'b0;
            end
            if (w_commit) begin
                r_show   <= State | r_mask;
                r_x      <= 4'(SPAWN_X);
                r_y      <= 5'(SPAWN_Y);
                r_active <= 1'b1;
            end
            if (w_fail) begin
                r_over <= 1'b1;
            end
            r_created <= w_ack_next;
        end
    end

    assign spawn_if.created = r_created;
    assign Show_State       = r_show;
    assign X_Pos            = r_x;
    assign Y_Pos            = r_y;
    assign piece_active     = r_active;
    assign game_over        = r_over;

endmodule

`default_nettype wire

// File: tb/tb_piece_spawner.sv
//------------------------------------------------------------------------------
// Module  : tb_piece_spawner
// Brief   : Directed plus randomized spawn sequences against a cell-list model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_piece_spawner;

    localparam int ROWS    = 24;
    localparam int COLS    = 10;
    localparam int SPAWN_X = 3;
    localparam int SPAWN_Y = 0;
    localparam int F       = ROWS * COLS;

    logic         Clk;
    logic         Reset_n;
    logic [F-1:0] State;
    logic [F-1:0] Show_State;
    logic [3:0]   X_Pos;
    logic [4:0]   Y_Pos;
    logic         piece_active;
    logic         game_over;

    piece_spawner_if u_if ();

    piece_spawner #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .SPAWN_X (SPAWN_X),
        .SPAWN_Y (SPAWN_Y)
    ) u_dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .spawn_if     (u_if.slave),
        .State        (State),
        .Show_State   (Show_State),
        .X_Pos        (X_Pos),
        .Y_Pos        (Y_Pos),
        .piece_active (piece_active),
        .game_over    (game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int           tests = 0;
    int           fails = 0;
    logic [F-1:0] exp_show;
    logic [3:0]   exp_x;
    logic [4:0]   exp_y;
    logic         exp_active;
    logic         exp_over;
    logic         exp_created;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [F-1:0] got, input logic [F-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".created"}, F'(u_if.created), F'(exp_created));
        check({tag, ".show"}, Show_State, exp_show);
        check({tag, ".x"}, F'(X_Pos), F'(exp_x));
        check({tag, ".y"}, F'(Y_Pos), F'(exp_y));
        check({tag, ".active"}, F'(piece_active), F'(exp_active));
        check({tag, ".over"}, F'(game_over), F'(exp_over));
    endtask

    // Cells of each piece at rotation 0 as (row, col) offsets from the spawn box corner
    function automatic logic [F-1:0] model_mask(input logic [2:0] t);
        int cr[4];
        int cc[4];
        logic [F-1:0] m;
        case (t)
            3'd0:    begin cr = '{0, 0, 0, 0}; cc = '{0, 1, 2, 3}; end
            3'd2:    begin cr = '{0, 1, 1, 1}; cc = '{1, 0, 1, 2}; end
            3'd3:    begin cr = '{0, 0, 1, 1}; cc = '{1, 2, 0, 1}; end
            3'd4:    begin cr = '{0, 0, 1, 1}; cc = '{0, 1, 1, 2}; end
            3'd5:    begin cr = '{0, 1, 1, 1}; cc = '{0, 0, 1, 2}; end
            3'd6:    begin cr = '{0, 1, 1, 1}; cc = '{2, 0, 1, 2}; end
            default: begin cr = '{0, 0, 1, 1}; cc = '{1, 2, 1, 2}; end
        endcase
        m = '0;
        for (int i = 0; i < 4; i++) begin
            int fr;
            int fc;
            fr = SPAWN_Y + cr[i];
            fc = SPAWN_X + cc[i];
            if (fr < ROWS && fc < COLS) m[fr*COLS + fc] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [F-1:0] rand_field();
        logic [F-1:0] f;
        for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = COLS'($urandom_range(0, (1 << COLS) - 1));
        return f;
    endfunction

    task automatic model_reset();
        exp_show    = '0;
        exp_x       = 4'd0;
        exp_y       = 5'd0;
        exp_active  = 1'b0;
        exp_over    = 1'b0;
        exp_created = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        u_if.create_block = 1'b0;
        tick();
        model_reset();
        check_all("reset");
        Reset_n = 1'b1;
    endtask

    // State is scrambled outside the CHECK cycle to show only that cycle is sampled
    task automatic spawn(input logic [2:0] t, input logic [F-1:0] st, input int hold);
        logic [F-1:0] m;
        m = model_mask(t);
        u_if.piece_type = t;
        if (exp_over) begin
            State = st;
            u_if.create_block = 1'b1;
            repeat (4) begin
                tick();
                check_all("ignored");
            end
            u_if.create_block = 1'b0;
            tick();
            return;
        end
        State = rand_field();
        u_if.create_block = 1'b1;
        tick();
        exp_active = 1'b0;
        check_all("load");
        tick();
        State = st;
        u_if.piece_type = 3'($urandom_range(0, 7));
        check_all("check");
        tick();
        if ((st & m) != '0) begin
            exp_over = 1'b1;
        end else begin
            exp_show    = st | m;
            exp_x       = 4'(SPAWN_X);
            exp_y       = 5'(SPAWN_Y);
            exp_active  = 1'b1;
            exp_created = 1'b1;
        end
        check_all("spawn");
        State = rand_field();
        repeat (hold) begin
            tick();
            check_all("hold");
        end
        u_if.create_block = 1'b0;
        tick();
        exp_created = 1'b0;
        check_all("release");
    endtask

    initial begin
        logic [F-1:0] st;
        logic [F-1:0] junk;
        logic [2:0]   t;

        Reset_n = 1'b0;
        u_if.create_block = 1'b0;
        u_if.piece_type = 3'd0;
        State = '0;
        tick();
        do_reset();

        spawn(3'd0, '0, 0);
        check("t1.row0", F'(Show_State[0 +: COLS]), F'(10'h078));

        spawn(3'd2, '0, 1);
        check("t2.row1", F'(Show_State[COLS +: COLS]), F'(10'h038));
        spawn(3'd7, '0, 0);
        check("t2.o_row1", F'(Show_State[COLS +: COLS]), F'(10'h030));

        st = '0;
        st[COLS +: COLS] = 10'h010;
        spawn(3'd2, st, 2);
        spawn(3'd0, '0, 0);
        do_reset();

        st = '0;
        st[5*COLS +: COLS] = 10'h3FF;
        spawn(3'd3, st, 0);
        check("t4.row5", F'(Show_State[5*COLS +: COLS]), F'(10'h3FF));

        spawn(3'd5, '0, 10);
        spawn(3'd6, '0, 0);

        State = '0;
        u_if.piece_type = 3'd1;
        u_if.create_block = 1'b1;
        tick();
        tick();
        Reset_n = 1'b0;
        tick();
        model_reset();
        check_all("t6.rst");
        Reset_n = 1'b1;
        u_if.create_block = 1'b0;
        tick();
        check_all("t6.idle");
        spawn(3'd4, '0, 0);

        for (int i = 0; i < 24; i++) begin
            t = 3'($urandom_range(0, 7));
            junk = rand_field();
            st = ($urandom_range(0, 3) == 0) ? junk : (junk & ~model_mask(t));
            spawn(t, st, $urandom_range(0, 3));
            if (exp_over) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
